// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MEM stage: stalls the pipeline with busywait_o
// while a req/ack transaction with the backing memory is in flight, aligns and
// extends load data, and lane-replicates store data with byte strobes.
module data_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busywait_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  // Last REQ cycle count before giving up; wraps harmlessly when TIMEOUT is 0.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  strb_q, strb_d;

  logic        access, request;
  logic [31:0] st_data, ld_data, lane_word;
  logic [3:0]  st_strb;
  logic [15:0] half;

  // Alignment check: byte never, half needs addr[0]=0, everything else is word.
  always_comb begin
    access       = mem_read_i | mem_write_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      3'b000, 3'b100: misaligned_o = 1'b0;
      3'b001, 3'b101: misaligned_o = access & addr_i[0];
      default:        misaligned_o = access & (addr_i[1:0] != 2'b00);
    endcase
    request = access & ~misaligned_o;
  end

  // Store packing: replicate the datum into every lane, strobe selects the lane.
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        st_data = {4{wdata_i[7:0]}};
        st_strb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        st_data = {2{wdata_i[15:0]}};
        st_strb = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wdata_i;
        st_strb = 4'b1111;
      end
    endcase
  end

  // Load extraction from the returned word, by lane and signedness.
  always_comb begin
    lane_word = mem_rdata_i >> {addr_i[1:0], 3'b000};
    half      = addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_i)
      3'b000:  ld_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b100:  ld_data = {24'h0, lane_word[7:0]};
      3'b001:  ld_data = {{16{half[15]}}, half};
      3'b101:  ld_data = {16'h0, half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Next-state and transaction register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (request) begin
        req_d   = 1'b1;
        we_d    = mem_write_i;
        addr_d  = {addr_i[31:2], 2'b00};
        wdata_d = mem_write_i ? st_data : 32'h0;
        strb_d  = mem_write_i ? st_strb : 4'b0000;
        cnt_d   = 32'h0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack_i) begin
          req_d   = 1'b0;
          err_d   = 1'b0;
          if (!we_q) rdata_d = ld_data;
          state_d = S_DONE;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      // Requests seen here belong to the instruction that is completing.
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
    end
  end

  assign busywait_o  = ((state_q == S_IDLE) & request) | (state_q == S_REQ);
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = strb_q;
  assign rdata_o     = rdata_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with TIMEOUT=4 and a hand-driven memory.
module tb_data_mem_ctrl;

  logic        clk = 1'b0, rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [2:0]  f3 = 3'b010;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        busywait, misaligned, bus_err, mreq, mwe;
  logic [31:0] rdata, maddr, mwdata;
  logic [3:0]  mstrb;
  logic        ack = 1'b0;
  logic [31:0] mrdata = 32'h0;

  int nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .mem_read_i(rd), .mem_write_i(wr),
    .funct3_i(f3), .addr_i(addr), .wdata_i(wdata), .busywait_o(busywait),
    .rdata_o(rdata), .misaligned_o(misaligned), .bus_err_o(bus_err),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_wstrb_o(mstrb), .mem_ack_i(ack),
    .mem_rdata_i(mrdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One access; ack_cyc is the cycle (counted from the request cycle 0) in
  // which ack is high, 0 = never ack.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word,
                        input int ack_cyc, input logic [31:0] e_rd,
                        input logic [31:0] e_addr, input logic [31:0] e_wd,
                        input logic [3:0] e_strb, input logic e_err,
                        input int e_bw, input int e_req);
    int bw, nreq;
    bit done, first;
    bw = 0; nreq = 0; done = 0; first = 1;
    @(posedge clk); #1;
    rd = r; wr = w; f3 = fn; addr = a; wdata = wd; ack = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c > 0 && !busywait) done = 1;
      else begin
        if (busywait) bw++;
        if (mreq) begin
          nreq++;
          if (first) begin
            chk({tag, " addr"}, maddr, e_addr);
            chk({tag, " we"}, {31'h0, mwe}, {31'h0, w});
            chk({tag, " wdata"}, mwdata, e_wd);
            chk({tag, " strb"}, {28'h0, mstrb}, {28'h0, e_strb});
            first = 0;
          end
        end
        ack = (ack_cyc != 0 && c == ack_cyc);
        mrdata = word;
      end
    end
    ack = 1'b0;
    chk({tag, " done"}, {31'h0, done}, 32'h1);
    chk({tag, " done req"}, {31'h0, mreq}, 32'h0);
    if (r && !w) chk({tag, " rdata"}, rdata, e_rd);
    chk({tag, " bus_err"}, {31'h0, bus_err}, {31'h0, e_err});
    chk({tag, " stall"}, bw, e_bw);
    chk({tag, " req cycles"}, nreq, e_req);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #12;
    @(negedge clk);
    chk("rst busy", {31'h0, busywait}, 32'h0);
    chk("rst req", {31'h0, mreq}, 32'h0);
    chk("rst rdata", rdata, 32'h0);
    rst = 1'b0;

    access("LW", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1,
           32'hDEADBEEF, 32'h100, 32'h0, 4'b0000, 0, 2, 1);
    access("LB", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1,
           32'hFFFFFF80, 32'h100, 32'h0, 4'b0000, 0, 2, 1);
    access("LBU", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2,
           32'h00000080, 32'h100, 32'h0, 4'b0000, 0, 3, 2);
    access("LH", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1,
           32'hFFFF8011, 32'h100, 32'h0, 4'b0000, 0, 2, 1);
    access("LHU", 1, 0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 3,
           32'h0000F00D, 32'h100, 32'h0, 4'b0000, 0, 4, 3);
    access("SH", 0, 1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 1,
           32'h0, 32'h204, 32'hABCDABCD, 4'b1100, 0, 2, 1);
    access("SB", 0, 1, 3'b000, 32'h301, 32'h0000005A, 32'h0, 2,
           32'h0, 32'h300, 32'h5A5A5A5A, 4'b0010, 0, 3, 2);
    access("RW", 1, 1, 3'b010, 32'h40C, 32'hCAFEF00D, 32'h0, 1,
           32'h0, 32'h40C, 32'hCAFEF00D, 4'b1111, 0, 2, 1);

    // Misaligned word and half: flag only, no stall, no transaction.
    @(posedge clk); #1;
    rd = 1'b1; f3 = 3'b010; addr = 32'h101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("misal LW flag", {31'h0, misaligned}, 32'h1);
      chk("misal LW busy", {31'h0, busywait}, 32'h0);
      chk("misal LW req", {31'h0, mreq}, 32'h0);
    end
    @(posedge clk); #1;
    f3 = 3'b001; addr = 32'h103;
    @(negedge clk);
    chk("misal LH flag", {31'h0, misaligned}, 32'h1);
    chk("misal LH busy", {31'h0, busywait}, 32'h0);
    @(posedge clk); #1;
    f3 = 3'b000;
    @(negedge clk);
    chk("LB odd flag", {31'h0, misaligned}, 32'h0);
    rd = 1'b0;
    @(negedge clk);
    chk("idle flag", {31'h0, misaligned}, 32'h0);

    // Reset while a request is outstanding.
    @(posedge clk); #1;
    rd = 1'b1; f3 = 3'b010; addr = 32'h500;
    @(negedge clk); @(negedge clk);
    chk("midreq req", {31'h0, mreq}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async drop", {31'h0, mreq}, 32'h0);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst busy", {31'h0, busywait}, 32'h0);
    chk("post-rst addr", maddr, 32'h0);
    chk("post-rst rdata", rdata, 32'h0);
    chk("post-rst req", {31'h0, mreq}, 32'h0);

    // Timeout: 4 REQ cycles, 5 stall cycles, error in DONE.
    access("TO", 1, 0, 3'b010, 32'h600, 32'h0, 32'h12345678, 0,
           32'h0, 32'h600, 32'h0, 4'b0000, 1, 5, 4);
    @(negedge clk);
    ack = 1'b1; mrdata = 32'hFFFFFFFF;
    @(negedge clk);
    ack = 1'b0;
    chk("late ack req", {31'h0, mreq}, 32'h0);
    chk("late ack busy", {31'h0, busywait}, 32'h0);
    chk("late ack rdata", rdata, 32'h0);

    // Normal access still works after a timeout and clears the error.
    access("LW2", 1, 0, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 1,
           32'h0BADF00D, 32'h700, 32'h0, 4'b0000, 0, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
